piso_ctrl: RTL and testbench
============================

Name: piso_ctrl

Overview:
- Controller and shift register for parallel-in/serial-out conversion.
- Accepts an N-bit word on a valid/ready handshake, then shifts it out MSB-first, one bit per CLK.
- Sequences load and shift enables internally with a small FSM and bit counter.
- Inserts a programmable idle gap between frames; sits between a word producer and a single-wire serial link.

Parameters:
N, 8, data word width in bits (2..32)
GAP, 1, idle cycles between frames (0..15); 0 allows back-to-back streaming

Ports:
CLK  input  1  clock, rising-edge active
N_RESET  input  1  asynchronous, active-low reset
DIN  input  N  parallel word to transmit
DIN_VALID  input  1  producer has a word on DIN
DIN_READY  output  1  controller can accept a word this cycle
SOUT  output  1  serial data out, MSB first
SOUT_VALID  output  1  SOUT carries a frame bit this cycle
FRAME_START  output  1  one-cycle pulse coincident with the first bit of each frame
BUSY  output  1  high in SHIFT or GAP state

Behaviour:
- Reset: N_RESET is asynchronous, active-low; clock is CLK.
  - While N_RESET=0: state=IDLE, shift reg=0, bit counter=0, gap counter=0.
  - Outputs during reset: SOUT=0, SOUT_VALID=0, FRAME_START=0, BUSY=0, DIN_READY=0.
  - Asserting reset mid-frame aborts the frame immediately; the partial word is discarded and not resent.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - DIN_READY=1, SOUT_VALID=0, SOUT=0.
  - On a rising edge with DIN_VALID=1: shift reg<=DIN, bit counter<=N-1, FRAME_START register set, go to SHIFT.
- SHIFT:
  - SOUT=shift reg[N-1], SOUT_VALID=1.
  - Each edge: shift reg shifts left (0 into LSB), bit counter decrements.
  - When bit counter==0 (last bit):
    - GAP>0: go to GAP, gap counter<=GAP-1.
    - GAP=0: go to IDLE.
  - GAP=0 back-to-back: DIN_READY=1 also during the last-bit cycle. A handshake there reloads the shift reg and stays in SHIFT, giving zero-bubble streaming. Otherwise DIN_READY=0 in SHIFT.
- GAP:
  - SOUT_VALID=0, SOUT=0, DIN_READY=0.
  - Gap counter decrements each edge; at 0, go to IDLE.
- Latency: word accepted at edge k → first bit valid in cycle after edge k. Frame occupies N consecutive cycles.
- FRAME_START is high only in the first SHIFT cycle of each frame, including back-to-back frames.
- DIN_VALID held high while DIN_READY=0 has no effect; DIN is sampled only on a handshake edge.
- DIN may change freely once a word has been accepted.
- Bit counter width is clog2(N+1). All counters must saturate/stop safely; no wrap to illegal states.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - The frame is N+1 bits: after the N data bits, SHIFT emits one even-parity bit (XOR of the accepted word) with SOUT_VALID=1.
  - Parity is latched at the handshake.
  - The back-to-back DIN_READY window moves to the parity cycle.
- Undefined:
  - The frame is exactly N bits; no parity logic is present.

Test Plan:
- Reset, N=8, GAP=1, DIN=8'hA5 with one-cycle DIN_VALID → SOUT=1,0,1,0,0,1,0,1 over 8 cycles. FRAME_START on the first bit, then 1 cycle with SOUT_VALID=0, then DIN_READY=1.
- GAP=0: send 8'hFF, then 8'h00 presented during the last bit → 16 consecutive SOUT_VALID cycles (8 ones, 8 zeros), two FRAME_START pulses 8 cycles apart.
- DIN_VALID held high with DIN changing every cycle during SHIFT → only the word at the handshake is transmitted. DIN_READY=0 throughout SHIFT (GAP=1).
- Reset asserted after the 3rd bit of 8'hC3 → all outputs 0 asynchronously. After release: IDLE, DIN_READY=1, no remaining bits emitted.
- GAP=3: two frames → exactly 3 idle cycles (SOUT_VALID=0, DIN_READY=0) between the last bit and DIN_READY=1.
- PISO_PARITY_EN defined: 8'hA5 → 9th bit 0; 8'h07 → 9th bit 1. BUSY high for 9+GAP cycles.

Source files
------------

// File: rtl/piso_ctrl.sv
// Parallel-in/serial-out controller: valid/ready word intake, MSB-first shift-out, idle gap.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_ctrl #(
  parameter int unsigned N   = 8,
  parameter int unsigned GAP = 1
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic [N-1:0] DIN,
  input  logic         DIN_VALID,
  output logic         DIN_READY,
  output logic         SOUT,
  output logic         SOUT_VALID,
  output logic         FRAME_START,
  output logic         BUSY
);

  localparam int unsigned CW = $clog2(N + 1);
`ifdef PISO_PARITY_EN
  localparam int unsigned LastIdx = N;
`else
  localparam int unsigned LastIdx = N - 1;
`endif
  localparam logic [CW-1:0] CntLoad = CW'(LastIdx);
  localparam logic [3:0]    GapLoad = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gap_q, gap_d;
  logic          start_q, start_d;
  logic          accept;
`ifdef PISO_PARITY_EN
  logic          parity_q, parity_d;
`endif

  assign accept = DIN_READY & DIN_VALID;

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      start_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      start_q  <= start_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    start_d  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: ;
      StShift: begin
        shift_d = {shift_q[N-2:0], 1'b0};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP > 0) begin
          state_d = StGap;
          gap_d   = GapLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // A handshake in IDLE or in the back-to-back window overrides the above.
    if (accept) begin
      state_d  = StShift;
      shift_d  = DIN;
      cnt_d    = CntLoad;
      start_d  = 1'b1;
`ifdef PISO_PARITY_EN
      parity_d = ^DIN;
`endif
    end
  end

  always_comb begin
    DIN_READY   = 1'b0;
    SOUT        = 1'b0;
    SOUT_VALID  = 1'b0;
    FRAME_START = start_q;
    BUSY        = (state_q != StIdle);
    if (N_RESET) begin
      DIN_READY = (state_q == StIdle) ||
                  ((GAP == 0) && (state_q == StShift) && (cnt_q == '0));
    end
    if (state_q == StShift) begin
      SOUT_VALID = 1'b1;
      SOUT       = shift_q[N-1];
`ifdef PISO_PARITY_EN
      if (cnt_q == '0) SOUT = parity_q;
`endif
    end
  end

endmodule

// File: tb/tb_piso_ctrl.sv
// Bench for piso_ctrl: three instances (GAP=1, GAP=0, GAP=3) checked against a bit-level
// scoreboard filled at each handshake and drained as SOUT_VALID bits appear.
module tb_piso_ctrl;

  localparam int N  = 8;
  localparam int ND = 3;
`ifdef PISO_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  function automatic int gap_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  din [ND];
  logic [ND-1:0] din_valid;
  logic [ND-1:0] din_ready, sout, sout_valid, frame_start, busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Entry: {last, first, bit}
  logic [2:0] sb [ND][$];
  int busy_run [ND];
  int gap_run [ND];
  int valid_run [ND];
  int max_valid_run [ND];

  always #5 clk = ~clk;

  piso_ctrl #(.N(N), .GAP(1)) u_gap1 (
    .CLK(clk), .N_RESET(rst_n), .DIN(din[0]), .DIN_VALID(din_valid[0]),
    .DIN_READY(din_ready[0]), .SOUT(sout[0]), .SOUT_VALID(sout_valid[0]),
    .FRAME_START(frame_start[0]), .BUSY(busy[0])
  );
  piso_ctrl #(.N(N), .GAP(0)) u_gap0 (
    .CLK(clk), .N_RESET(rst_n), .DIN(din[1]), .DIN_VALID(din_valid[1]),
    .DIN_READY(din_ready[1]), .SOUT(sout[1]), .SOUT_VALID(sout_valid[1]),
    .FRAME_START(frame_start[1]), .BUSY(busy[1])
  );
  piso_ctrl #(.N(N), .GAP(3)) u_gap3 (
    .CLK(clk), .N_RESET(rst_n), .DIN(din[2]), .DIN_VALID(din_valid[2]),
    .DIN_READY(din_ready[2]), .SOUT(sout[2]), .SOUT_VALID(sout_valid[2]),
    .FRAME_START(frame_start[2]), .BUSY(busy[2])
  );

  task automatic check(input string tag, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", tag, idx, got, exp, $time);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (!rst_n) begin
        check("rst_out", i,
              {din_ready[i], sout[i], sout_valid[i], frame_start[i], busy[i]}, 0);
        sb[i].delete();
        busy_run[i]  = 0;
        gap_run[i]   = 0;
        valid_run[i] = 0;
      end else begin
        if (sout_valid[i]) begin
          valid_run[i]++;
          if (valid_run[i] > max_valid_run[i]) max_valid_run[i] = valid_run[i];
          gap_run[i] = 0;
          if (sb[i].size() == 0) begin
            check("extra_bit", i, sout_valid[i], 0);
          end else begin
            logic [2:0] e;
            e = sb[i].pop_front();
            check("bit", i, {frame_start[i], sout[i]}, {e[1], e[0]});
            check("shift_ready", i, din_ready[i], (gap_of(i) == 0) && e[2]);
          end
        end else begin
          valid_run[i] = 0;
          check("idle_out", i, {sout[i], frame_start[i]}, 0);
          if (busy[i]) begin
            gap_run[i]++;
            check("gap_ready", i, din_ready[i], 0);
          end else begin
            if (gap_run[i] > 0) check("gap_len", i, gap_run[i], gap_of(i));
            gap_run[i] = 0;
            check("idle_ready", i, din_ready[i], 1);
          end
        end
        if (busy[i]) begin
          busy_run[i]++;
        end else begin
          if (busy_run[i] > 0 && gap_of(i) > 0)
            check("busy_len", i, busy_run[i], FRAME + gap_of(i));
          busy_run[i] = 0;
        end
        // Handshake takes effect at the coming rising edge; DIN is stable until then.
        if (din_ready[i] && din_valid[i]) begin
          for (int k = 0; k < FRAME; k++) begin
            logic v;
            v = (k < N) ? din[i][N-1-k] : ^din[i];
            sb[i].push_back({(k == FRAME - 1), (k == 0), v});
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [N-1:0] w);
    int t;
    din[i]       = w;
    din_valid[i] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!din_ready[i] && t < 200);
    if (!din_ready[i]) check("hs_timeout", i, din_ready[i], 1);
    @(posedge clk);
    #1;
    din_valid[i] = 1'b0;
    din[i]       = N'($urandom);
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    din_valid = '0;
    for (int i = 0; i < ND; i++) begin
      din[i] = '0;
      max_valid_run[i] = 0;
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    settle(2);

    // Single frame with gap, then a parity-distinguishing word.
    send(0, 8'hA5);
    settle(FRAME + 4);
    send(0, 8'h07);
    settle(FRAME + 4);

    // Zero-bubble streaming on the GAP=0 instance.
    send(1, 8'hFF);
    send(1, 8'h00);
    settle(FRAME + 4);

    // DIN_VALID held high with DIN churning every cycle.
    din_valid[0] = 1'b1;
    repeat (3 * (FRAME + 2)) begin
      din[0] = N'($urandom);
      @(posedge clk);
      #1;
    end
    din_valid[0] = 1'b0;
    settle(FRAME + 4);

    // Abort mid-frame after the third bit.
    send(0, 8'hC3);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 0, {din_ready[0], sout[0], sout_valid[0], frame_start[0], busy[0]}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 0, {din_ready[0], busy[0], sout_valid[0]}, 3'b100);
    settle(FRAME + 4);

    // Two frames separated by a 3-cycle gap.
    send(2, 8'h3C);
    send(2, 8'h81);
    settle(FRAME + 8);

    for (int i = 0; i < ND; i++) check("drain", i, sb[i].size(), 0);
    check("b2b_run", 1, max_valid_run[1], 2 * FRAME);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
